cp_dmem_vec_seq: RTL

//  Sequencer for the CP cluster data memory (read ports A/B, read/write port C, 1-cycle registered read).

---
 rtl/cp_dmem_vec_seq_pkg.sv | 15 +
 rtl/cp_dmem_vec_seq_delay_line.sv | 36 +++
 rtl/cp_dmem_vec_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cp_dmem_vec_seq_pkg.sv
// Shared defaults and sequencer state encoding for the CP dmem vector sequencer.
package cp_dmem_vec_seq_pkg;

    localparam int DEF_D_WIDTH    = 72;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FU_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/cp_dmem_vec_seq_delay_line.sv
// Valid + payload shift register. A stage's payload only loads on a valid
// input, so the tail keeps the last delivered payload while the line is idle.
module cp_dmem_vec_seq_delay_line #(
    parameter int DEPTH = 3,
    parameter int W     = 10
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             in_vld,
    input  logic [W-1:0]     in_data,
    output logic [DEPTH:0]   vld_pipe,
    output logic [W-1:0]     out_data
);

    logic [DEPTH:1]        vld_q;
    logic [DEPTH:1][W-1:0] data_q;

    // Shift valid bits every cycle; move payload only alongside a valid bit.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[1] <= in_vld;
            if (in_vld) data_q[1] <= in_data;
            for (int k = 2; k <= DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    assign vld_pipe = {vld_q, in_vld};
    assign out_data = data_q[DEPTH];

endmodule

// File: rtl/cp_dmem_vec_seq.sv
// Element-wise vector sequencer for the CP data memory: reads A[i]/B[i],
// flags operands to a fixed-latency FU, and writes the FU result to C[i].
module cp_dmem_vec_seq
    import cp_dmem_vec_seq_pkg::*;
#(
    parameter int CP_D_WIDTH      = DEF_D_WIDTH,
    parameter int DMEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FU_LATENCY      = DEF_FU_LATENCY
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DMEM_ADDR_WIDTH-1:0] base_a,
    input  logic [DMEM_ADDR_WIDTH-1:0] base_b,
    input  logic [DMEM_ADDR_WIDTH-1:0] base_c,
    input  logic [DMEM_ADDR_WIDTH:0]   vlen,
    output logic                       busy,
    output logic                       done,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_a,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_b,
    output logic                       fu_in_valid,
    input  logic [CP_D_WIDTH-1:0]      fu_result,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_c,
    output logic [CP_D_WIDTH-1:0]      dmem_in_c,
    output logic                       dmem_we_c
);

    localparam int AW    = DMEM_ADDR_WIDTH;
    localparam int DEPTH = FU_LATENCY + 1;

    seq_state_e    state_q, state_d;
    logic [AW:0]   cnt_q, vlen_q, cnt_inc, idx;
    logic [AW-1:0] base_a_q, base_b_q, base_c_q;
    logic [AW-1:0] sel_a, sel_b, sel_c;
    logic [AW-1:0] iss_addr_c_q;
    logic          iss_vld_q;
    logic          accept, issue, load, pending;
    logic [DEPTH:0] vld_pipe;

    assign cnt_inc = cnt_q + (AW+1)'(1);

    // Next-state: accept in IDLE only; RUN issues one element per cycle until
    // count reached or abort; DRAIN waits until only the tail can still hold a write.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (vlen == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || cnt_q == vlen_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue = 1'b1;
                    if (cnt_inc == vlen_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (!pending) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Element 0 is issued on the accept edge itself, using the live base inputs.
    assign load  = issue | (accept & (vlen != '0));
    assign idx   = accept ? '0 : cnt_q;
    assign sel_a = accept ? base_a : base_a_q;
    assign sel_b = accept ? base_b : base_b_q;
    assign sel_c = accept ? base_c : base_c_q;

    // State, latched operands, counter and registered issue addresses.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            vlen_q       <= '0;
            base_a_q     <= '0;
            base_b_q     <= '0;
            base_c_q     <= '0;
            dmem_addr_a  <= '0;
            dmem_addr_b  <= '0;
            iss_addr_c_q <= '0;
            iss_vld_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            iss_vld_q <= load;
            if (accept) begin
                base_a_q <= base_a;
                base_b_q <= base_b;
                base_c_q <= base_c;
                vlen_q   <= vlen;
            end
            if (load) begin
                dmem_addr_a  <= sel_a + idx[AW-1:0];
                dmem_addr_b  <= sel_b + idx[AW-1:0];
                iss_addr_c_q <= sel_c + idx[AW-1:0];
                cnt_q        <= idx + (AW+1)'(1);
            end else if (accept) begin
                cnt_q <= '0;
            end
        end
    end

    cp_dmem_vec_seq_delay_line #(
        .DEPTH (DEPTH),
        .W     (AW)
    ) u_dly (
        .clock    (clock),
        .nreset   (nreset),
        .in_vld   (iss_vld_q),
        .in_data  (iss_addr_c_q),
        .vld_pipe (vld_pipe),
        .out_data (dmem_addr_c)
    );

    assign pending     = |vld_pipe[DEPTH-1:0];
    assign fu_in_valid = vld_pipe[1];
    assign dmem_we_c   = vld_pipe[DEPTH];
    assign dmem_in_c   = fu_result;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);

endmodule
